// File: rtl/emulib_ready_valid_dispatch_pkg.sv
// Shared constants for the emulib ready/valid buffers (dispatcher side and arbiter side).
// Holds the buffer depth and the matching occupancy-count width.
package emulib_ready_valid_dispatch_pkg;

    localparam int RV_BUF_DEPTH = 2;
    localparam int RV_CNT_W     = $clog2(RV_BUF_DEPTH + 1);

endpackage

// File: rtl/emulib_rv_fifo2.sv
// Two-entry synchronous FIFO with registered occupancy; ready/valid derive only from the count.
// Storage is cleared on reset so the head reads zero until the first write.
module emulib_rv_fifo2
    import emulib_ready_valid_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  ready,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] pop_data
);

    logic [DATA_WIDTH-1:0] mem [RV_BUF_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [RV_CNT_W-1:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign ready    = (count != RV_CNT_W'(RV_BUF_DEPTH));
    assign valid    = (count != '0);
    assign pop_data = mem[rd_ptr];
    assign do_push  = push && ready;
    assign do_pop   = pop && valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < RV_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (do_push && !do_pop) begin
                count <= count + RV_CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - RV_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/emulib_ready_valid_dispatch.sv
// One-to-many ready/valid dispatcher: each beat goes to the buffer(s) named by s_sel.
// Define EMULIB_RV_DISPATCH_BCAST_EN to accept multi-hot s_sel as a broadcast.
module emulib_ready_valid_dispatch #(
    parameter int NUM_M      = 2,
    parameter int DATA_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic [NUM_M-1:0]            s_sel,
    output logic [NUM_M-1:0]            m_valid,
    input  logic [NUM_M-1:0]            m_ready,
    output logic [DATA_WIDTH*NUM_M-1:0] m_data,
    output logic                        err_sel,
    input  logic                        err_clr
);

    // Handshake: a beat transfers on a rising edge where valid && ready. s_ready depends only on
    // s_sel and registered buffer counts (never on m_ready); illegal selects are always ready and dropped.
    logic [NUM_M-1:0] buf_ready;
    logic [NUM_M-1:0] push;
    logic             sel_legal;
    logic             sel_blocked;
    logic             push_en;

`ifdef EMULIB_RV_DISPATCH_BCAST_EN
    assign sel_legal = (s_sel != '0);
`else
    logic [NUM_M-1:0] sel_minus_one;
    assign sel_minus_one = s_sel - NUM_M'(1);
    assign sel_legal     = (s_sel != '0) && ((s_sel & sel_minus_one) == '0);
`endif

    // All selected buffers must have room, so a broadcast is never written partially.
    assign sel_blocked = |(s_sel & ~buf_ready);
    assign s_ready     = !(sel_legal && sel_blocked);
    assign push_en     = s_valid && s_ready && sel_legal;
    assign push        = push_en ? s_sel : '0;

    for (genvar k = 0; k < NUM_M; k++) begin : g_buf
        emulib_rv_fifo2 #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_fifo (
            .clk      (clk),
            .resetn   (resetn),
            .push     (push[k]),
            .push_data(s_data),
            .ready    (buf_ready[k]),
            .pop      (m_ready[k]),
            .valid    (m_valid[k]),
            .pop_data (m_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_sel <= 1'b0;
        end else if (s_valid && !sel_legal) begin
            err_sel <= 1'b1;
        end else if (err_clr) begin
            err_sel <= 1'b0;
        end
    end

endmodule
